apb_cmd_master: RTL and testbench

APB requester (master) that turns a valid/ready command stream into single APB3 transfers, each with a valid/ready response. Sits on the other end of the peripheral APB bus, e.g. driving the SHA-256 APB slave from a test sequencer or a small control core. It issues one transfer at a time, detects misaligned addresses locally, and aborts stalled transfers with a timeout error.

---
 rtl/apb_cmd_master_if.sv | 32 +++
 rtl/apb_cmd_master.sv | 80 ++++++++
 tb/tb_apb_cmd_master.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/apb_cmd_master_if.sv
// apb_cmd_master_if: command/response stream plus APB3 bus seen by apb_cmd_master
interface apb_cmd_master_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PWRITE;
  logic              PSEL;
  logic              PENABLE;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );
endinterface

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: one-at-a-time APB3 requester driven by a valid/ready command stream
module apb_cmd_master #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst,
  apb_cmd_master_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 2);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              pwrite_q, err_q, tmo_q;
  logic              accept, misaligned, done, to_hit;
  assign accept     = state_q == IDLE && bus.cmd_valid;
  assign misaligned = bus.cmd_addr[1:0] != 2'b00;
  assign done       = state_q == ACCESS && bus.PREADY;
  // abort on the edge that ends the TIMEOUT-th stalled ACCESS cycle
  assign to_hit     = TIMEOUT != 0 && state_q == ACCESS && !bus.PREADY && cnt == CW'(TIMEOUT - 1);
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.rsp_timeout = tmo_q;
  always_comb begin
    state_d       = state_q;
    bus.cmd_ready = state_q == IDLE;
    bus.rsp_valid = state_q == RESP;
    bus.PSEL      = state_q == SETUP || state_q == ACCESS;
    bus.PENABLE   = state_q == ACCESS;
    unique case (state_q)
      IDLE:    state_d = bus.cmd_valid ? (misaligned ? RESP : SETUP) : IDLE;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = (done || to_hit) ? RESP : ACCESS;
      RESP:    state_d = bus.rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt      <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt     <= (state_q == ACCESS && !bus.PREADY && !to_hit) ? cnt + 1'b1 : '0;
      if (accept) begin
        paddr_q  <= bus.cmd_addr;
        pwdata_q <= bus.cmd_wdata;
        pwrite_q <= bus.cmd_write;
      end
      if (accept && misaligned) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
        tmo_q   <= 1'b0;
      end
      if (done) begin
        rdata_q <= (!pwrite_q && !bus.PSLVERR) ? bus.PRDATA : '0;
        err_q   <= bus.PSLVERR;
        tmo_q   <= 1'b0;
      end
      if (to_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
        tmo_q   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed checks of apb_cmd_master with TIMEOUT=8
module tb_apb_cmd_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int passed = 0;
  int fails = 0;
  apb_cmd_master_if #(.ADDR_W(12), .DATA_W(32)) bus ();
  apb_cmd_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic issue(input logic w, input logic [11:0] a, input logic [31:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
  endtask
  task automatic chk_reset(input string p);
    chk({p, " psel"}, bus.PSEL, 0);
    chk({p, " penable"}, bus.PENABLE, 0);
    chk({p, " pwrite"}, bus.PWRITE, 0);
    chk({p, " paddr"}, bus.PADDR, 0);
    chk({p, " pwdata"}, bus.PWDATA, 0);
    chk({p, " rsp_valid"}, bus.rsp_valid, 0);
    chk({p, " rsp_rdata"}, bus.rsp_rdata, 0);
    chk({p, " rsp_err"}, bus.rsp_err, 0);
    chk({p, " rsp_timeout"}, bus.rsp_timeout, 0);
    chk({p, " cmd_ready"}, bus.cmd_ready, 1);
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b1;
    bus.PSLVERR   = 1'b0;
    repeat (2) tick();
    chk_reset("reset");
    rst = 1'b0;
    tick();
    // zero-wait write
    chk("t1 cmd_ready", bus.cmd_ready, 1);
    issue(1'b1, 12'h004, 32'hDEADBEEF);
    tick();
    bus.cmd_valid = 1'b0;
    chk("t1 setup psel", bus.PSEL, 1);
    chk("t1 setup penable", bus.PENABLE, 0);
    chk("t1 pwrite", bus.PWRITE, 1);
    chk("t1 paddr", bus.PADDR, 32'h004);
    chk("t1 pwdata", bus.PWDATA, 32'hDEADBEEF);
    chk("t1 busy cmd_ready", bus.cmd_ready, 0);
    tick();
    chk("t1 access psel", bus.PSEL, 1);
    chk("t1 access penable", bus.PENABLE, 1);
    tick();
    chk("t1 resp psel", bus.PSEL, 0);
    chk("t1 resp penable", bus.PENABLE, 0);
    chk("t1 rsp_valid", bus.rsp_valid, 1);
    chk("t1 rsp_err", bus.rsp_err, 0);
    chk("t1 rsp_rdata", bus.rsp_rdata, 0);
    tick();
    chk("t1 done rsp_valid", bus.rsp_valid, 0);
    chk("t1 done cmd_ready", bus.cmd_ready, 1);
    // read with three wait states
    issue(1'b0, 12'h010, 32'h0);
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'h6A09E667;
    tick();
    bus.cmd_valid = 1'b0;
    chk("t2 setup penable", bus.PENABLE, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2 penable %0d", i), bus.PENABLE, 1);
      chk($sformatf("t2 paddr %0d", i), bus.PADDR, 32'h010);
      if (i == 3) bus.PREADY = 1'b1;
      tick();
    end
    chk("t2 resp penable", bus.PENABLE, 0);
    chk("t2 rsp_valid", bus.rsp_valid, 1);
    chk("t2 rsp_rdata", bus.rsp_rdata, 32'h6A09E667);
    chk("t2 rsp_err", bus.rsp_err, 0);
    tick();
    // read with slave error
    issue(1'b0, 12'h020, 32'h0);
    bus.PRDATA = 32'h12345678;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    bus.PSLVERR = 1'b1;
    chk("t3 penable", bus.PENABLE, 1);
    tick();
    bus.PSLVERR = 1'b0;
    chk("t3 rsp_valid", bus.rsp_valid, 1);
    chk("t3 rsp_err", bus.rsp_err, 1);
    chk("t3 rsp_timeout", bus.rsp_timeout, 0);
    chk("t3 rsp_rdata", bus.rsp_rdata, 0);
    tick();
    // timeout after 8 stalled ACCESS cycles
    bus.PREADY = 1'b0;
    issue(1'b0, 12'h030, 32'h0);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4 penable %0d", i), bus.PENABLE, 1);
      chk($sformatf("t4 psel %0d", i), bus.PSEL, 1);
      tick();
    end
    chk("t4 psel dropped", bus.PSEL, 0);
    chk("t4 penable dropped", bus.PENABLE, 0);
    chk("t4 rsp_valid", bus.rsp_valid, 1);
    chk("t4 rsp_err", bus.rsp_err, 1);
    chk("t4 rsp_timeout", bus.rsp_timeout, 1);
    chk("t4 rsp_rdata", bus.rsp_rdata, 0);
    bus.PREADY = 1'b1;
    tick();
    issue(1'b1, 12'h000, 32'h11223344);
    tick();
    bus.cmd_valid = 1'b0;
    chk("t4b paddr", bus.PADDR, 0);
    chk("t4b pwdata", bus.PWDATA, 32'h11223344);
    tick();
    chk("t4b penable", bus.PENABLE, 1);
    tick();
    chk("t4b rsp_valid", bus.rsp_valid, 1);
    chk("t4b rsp_err", bus.rsp_err, 0);
    chk("t4b rsp_timeout", bus.rsp_timeout, 0);
    tick();
    // misaligned command, response back-pressured while next command waits
    bus.rsp_ready = 1'b0;
    issue(1'b0, 12'h006, 32'h0);
    tick();
    issue(1'b1, 12'h008, 32'hCAFEF00D);
    bus.PREADY = 1'b0;
    chk("t5 paddr", bus.PADDR, 32'h006);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5 rsp_valid %0d", i), bus.rsp_valid, 1);
      chk($sformatf("t5 rsp_err %0d", i), bus.rsp_err, 1);
      chk($sformatf("t5 rsp_timeout %0d", i), bus.rsp_timeout, 0);
      chk($sformatf("t5 rsp_rdata %0d", i), bus.rsp_rdata, 0);
      chk($sformatf("t5 cmd_ready %0d", i), bus.cmd_ready, 0);
      chk($sformatf("t5 psel %0d", i), bus.PSEL, 0);
      if (i == 4) bus.rsp_ready = 1'b1;
      tick();
    end
    chk("t5 idle rsp_valid", bus.rsp_valid, 0);
    chk("t5 idle cmd_ready", bus.cmd_ready, 1);
    chk("t5 held rsp_err", bus.rsp_err, 1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("t6 setup psel", bus.PSEL, 1);
    chk("t6 paddr", bus.PADDR, 32'h008);
    tick();
    chk("t6 wait1 penable", bus.PENABLE, 1);
    tick();
    chk("t6 wait2 penable", bus.PENABLE, 1);
    rst = 1'b1;
    tick();
    chk_reset("t6 reset");
    rst = 1'b0;
    tick();
    chk("t6 post cmd_ready", bus.cmd_ready, 1);
    chk("t6 post psel", bus.PSEL, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
